// File: rtl/id_scoreboard_pkg.sv
// Shared definitions for the ID-stage register scoreboard.
// Latency codes, default field width and small index helpers used by
// id_scoreboard and sb_entry.
package id_scoreboard_pkg;

    // Latency codes carried on id_lat
    localparam int SB_LAT_ALU  = 0;
    localparam int SB_LAT_LOAD = 1;
    localparam int SB_LAT_W    = 3;

    // Counter update selected for one register in a given cycle
    typedef enum logic [1:0] {
        UPD_HOLD  = 2'd0,
        UPD_ISSUE = 2'd1,
        UPD_DONE  = 2'd2,
        UPD_DEC   = 2'd3
    } sb_upd_e;

    // All-ones latency code: producer finishes asynchronously via lc_done
    function automatic int sb_lat_max(input int w);
        return (1 << w) - 1;
    endfunction

    // LSB of read port 'port' inside a packed address bus
    function automatic int sb_port_lsb(input int port, input int aw);
        return port * aw;
    endfunction

endpackage

// File: rtl/id_scoreboard_sb_entry.sv
// sb_entry: ready countdown for one architectural register.
// Priority: new issue > long-latency completion > advancing decrement.
// The all-ones value is sticky and is only cleared by a matching done.
module sb_entry
    import id_scoreboard_pkg::*;
#(
    parameter int LAT_W = SB_LAT_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             adv,
    input  logic             issue_hit,
    input  logic             done_hit,
    input  logic [LAT_W-1:0] lat,
    output logic [LAT_W-1:0] cnt
);

    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(sb_lat_max(LAT_W));

    sb_upd_e upd;

    // Choose this cycle's update according to the fixed priority order
    always_comb begin
        upd = UPD_HOLD;
        if (issue_hit) begin
            upd = UPD_ISSUE;
        end else if (done_hit && (cnt == LAT_MAX)) begin
            upd = UPD_DONE;
        end else if (adv && (cnt != '0) && (cnt != LAT_MAX)) begin
            upd = UPD_DEC;
        end
    end

    // Counter register; reset discards any pending producer
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            case (upd)
                UPD_ISSUE: cnt <= lat;
                UPD_DONE:  cnt <= '0;
                UPD_DEC:   cnt <= cnt - LAT_W'(1);
                default:   cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/id_scoreboard.sv
// id_scoreboard: per-register ready countdowns for the ID stage.
// Raises stall_req when any used source register still has a producer
// whose result is not yet forwardable. Register 0 is never tracked.
// Optional macro SCOREBOARD_PERF_EN adds perf_stall_cycles and
// perf_lc_pending outputs.
module id_scoreboard
    import id_scoreboard_pkg::*;
#(
    parameter int NREG  = 32,
    parameter int AW    = 5,
    parameter int NRD   = 2,
    parameter int LAT_W = SB_LAT_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              adv,
    input  logic              id_valid,
    input  logic [NRD-1:0]    id_rs_en,
    input  logic [NRD*AW-1:0] id_raddr,
    input  logic              id_we,
    input  logic [AW-1:0]     id_waddr,
    input  logic [LAT_W-1:0]  id_lat,
    input  logic              lc_done,
    input  logic [AW-1:0]     lc_waddr,
    output logic              stall_req,
    output logic              issue_fire,
    output logic [NRD-1:0]    port_busy
`ifdef SCOREBOARD_PERF_EN
    ,
    output logic [31:0]       perf_stall_cycles,
    output logic              perf_lc_pending
`endif
);

    // Flattened counters; slot 0 is the hardwired-zero register
    logic [NREG*LAT_W-1:0] cnt_flat;
    logic [AW-1:0]         raddr;

    assign cnt_flat[LAT_W-1:0] = '0;

    genvar r;
    generate
        for (r = 1; r < NREG; r++) begin : g_entry
            logic issue_hit;
            logic done_hit;

            assign issue_hit = issue_fire & id_we & (id_waddr == AW'(r));
            assign done_hit  = lc_done & (lc_waddr == AW'(r));

            sb_entry #(
                .LAT_W(LAT_W)
            ) u_entry (
                .clk      (clk),
                .rst      (rst),
                .adv      (adv),
                .issue_hit(issue_hit),
                .done_hit (done_hit),
                .lat      (id_lat),
                .cnt      (cnt_flat[r*LAT_W +: LAT_W])
            );
        end
    endgenerate

    // Per-port hazard check against the pre-update counters
    always_comb begin
        port_busy = '0;
        raddr     = '0;
        for (int i = 0; i < NRD; i++) begin
            raddr = id_raddr[sb_port_lsb(i, AW) +: AW];
            port_busy[i] = id_valid & id_rs_en[i] & (raddr != '0) &
                           (cnt_flat[int'(raddr)*LAT_W +: LAT_W] != '0);
        end
    end

    assign stall_req  = |port_busy;
    assign issue_fire = id_valid & adv & ~stall_req;

`ifdef SCOREBOARD_PERF_EN
    localparam logic [LAT_W-1:0] LAT_MAX = LAT_W'(sb_lat_max(LAT_W));

    // Count cycles in which a valid ID instruction is held by a hazard
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_cycles <= '0;
        end else if (id_valid && stall_req) begin
            perf_stall_cycles <= perf_stall_cycles + 32'd1;
        end
    end

    // Flag any register still waiting on a long-latency unit
    always_comb begin
        perf_lc_pending = 1'b0;
        for (int k = 1; k < NREG; k++) begin
            if (cnt_flat[k*LAT_W +: LAT_W] == LAT_MAX) begin
                perf_lc_pending = 1'b1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_id_scoreboard.sv
// Directed self-checking bench for id_scoreboard.
// Inputs change on the falling edge; outputs are checked 1 time unit
// later, well away from the rising (active) edge.
module tb_id_scoreboard;
    import id_scoreboard_pkg::*;

    localparam logic [2:0] LMAX = 3'd7;

    logic        clk;
    logic        rst;
    logic        adv;
    logic        id_valid;
    logic [1:0]  id_rs_en;
    logic [9:0]  id_raddr;
    logic        id_we;
    logic [4:0]  id_waddr;
    logic [2:0]  id_lat;
    logic        lc_done;
    logic [4:0]  lc_waddr;
    logic        stall_req;
    logic        issue_fire;
    logic [1:0]  port_busy;
`ifdef SCOREBOARD_PERF_EN
    logic [31:0] perf_stall_cycles;
    logic        perf_lc_pending;
`endif

    int nvec;
    int nmis;
    int exp_perf;

    id_scoreboard dut (
        .clk       (clk),
        .rst       (rst),
        .adv       (adv),
        .id_valid  (id_valid),
        .id_rs_en  (id_rs_en),
        .id_raddr  (id_raddr),
        .id_we     (id_we),
        .id_waddr  (id_waddr),
        .id_lat    (id_lat),
        .lc_done   (lc_done),
        .lc_waddr  (lc_waddr),
        .stall_req (stall_req),
        .issue_fire(issue_fire),
        .port_busy (port_busy)
`ifdef SCOREBOARD_PERF_EN
        ,
        .perf_stall_cycles(perf_stall_cycles),
        .perf_lc_pending  (perf_lc_pending)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so the bench can never hang
    initial begin
        #200000;
        $display("[TB] FAIL timeout observed=running required=finished");
        $fatal(1, "[TB] time limit");
    end

    // Wait for the falling edge, then drive one ID-stage vector
    task automatic applyStimulus(input logic v, input logic [1:0] en,
                                 input logic [4:0] r0, input logic [4:0] r1,
                                 input logic we, input logic [4:0] wa,
                                 input logic [2:0] lat, input logic a,
                                 input logic d, input logic [4:0] dwa);
        @(negedge clk);
        id_valid = v;
        id_rs_en = en;
        id_raddr = {r1, r0};
        id_we    = we;
        id_waddr = wa;
        id_lat   = lat;
        adv      = a;
        lc_done  = d;
        lc_waddr = dwa;
    endtask

    // Compare the three core outputs against hand-computed values
    task automatic checkOutput(input string tag, input logic es,
                               input logic ef, input logic [1:0] eb);
        #1;
        nvec++;
        assert (stall_req === es) else begin
            nmis++;
            $error("[TB] FAIL %s stall_req observed=%0b expected=%0b", tag, stall_req, es);
        end
        nvec++;
        assert (issue_fire === ef) else begin
            nmis++;
            $error("[TB] FAIL %s issue_fire observed=%0b expected=%0b", tag, issue_fire, ef);
        end
        nvec++;
        assert (port_busy === eb) else begin
            nmis++;
            $error("[TB] FAIL %s port_busy observed=%b expected=%b", tag, port_busy, eb);
        end
        if (es) exp_perf++;
    endtask

    // Synchronous reset held for two rising edges with ID idle
    task automatic doReset();
        @(negedge clk);
        rst      = 1'b1;
        id_valid = 1'b0;
        id_we    = 1'b0;
        lc_done  = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        exp_perf = 0;
    endtask

    initial begin
        nvec = 0;
        nmis = 0;
        exp_perf = 0;
        rst = 1'b1;
        adv = 1'b1;
        id_valid = 1'b0;
        id_rs_en = 2'b00;
        id_raddr = '0;
        id_we = 1'b0;
        id_waddr = '0;
        id_lat = '0;
        lc_done = 1'b0;
        lc_waddr = '0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Reset state and a simple reader
        applyStimulus(0, 2'b00, 5'd0, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("reset_idle", 0, 0, 2'b00);
        applyStimulus(1, 2'b01, 5'd5, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("reset_read5", 0, 1, 2'b00);

        // Load-use: one bubble
        applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd8, 3'(SB_LAT_LOAD), 1, 0, 5'd0);
        checkOutput("lw8_issue", 0, 1, 2'b00);
        applyStimulus(1, 2'b01, 5'd8, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("lw8_bubble", 1, 0, 2'b01);
        applyStimulus(1, 2'b01, 5'd8, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("lw8_go", 0, 1, 2'b00);

        // Load-use at distance 2: no stall
        applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd12, 3'(SB_LAT_LOAD), 1, 0, 5'd0);
        checkOutput("lw12_issue", 0, 1, 2'b00);
        applyStimulus(1, 2'b00, 5'd0, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("lw12_gap", 0, 1, 2'b00);
        applyStimulus(1, 2'b10, 5'd0, 5'd12, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("lw12_dist2", 0, 1, 2'b00);

        // Frozen pipe: lat 3 to $9, counters hold while adv = 0
        applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd9, 3'd3, 1, 0, 5'd0);
        checkOutput("r9_issue", 0, 1, 2'b00);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1, 2'b01, 5'd9, 5'd0, 0, 5'd0, 3'd0, 0, 0, 5'd0);
            checkOutput("r9_frozen", 1, 0, 2'b01);
        end
        for (int k = 0; k < 3; k++) begin
            applyStimulus(1, 2'b01, 5'd9, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
            checkOutput("r9_count", 1, 0, 2'b01);
        end
        applyStimulus(1, 2'b01, 5'd9, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("r9_go", 0, 1, 2'b00);

        // Long latency on $10: sticky until lc_done
        applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd10, LMAX, 1, 0, 5'd0);
        checkOutput("r10_issue", 0, 1, 2'b00);
        for (int k = 0; k < 20; k++) begin
            applyStimulus(1, 2'b10, 5'd0, 5'd10, 0, 5'd0, 3'd0, 1, 0, 5'd0);
            checkOutput("r10_wait", 1, 0, 2'b10);
        end
`ifdef SCOREBOARD_PERF_EN
        nvec++;
        assert (perf_lc_pending === 1'b1) else begin
            nmis++;
            $error("[TB] FAIL lc_pending_set observed=%0b expected=1", perf_lc_pending);
        end
`endif
        applyStimulus(1, 2'b10, 5'd0, 5'd10, 0, 5'd0, 3'd0, 1, 1, 5'd10);
        checkOutput("r10_done_cycle", 1, 0, 2'b10);
        applyStimulus(1, 2'b10, 5'd0, 5'd10, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("r10_released", 0, 1, 2'b00);
`ifdef SCOREBOARD_PERF_EN
        nvec++;
        assert (perf_lc_pending === 1'b0) else begin
            nmis++;
            $error("[TB] FAIL lc_pending_clr observed=%0b expected=0", perf_lc_pending);
        end
`endif

        // WAW with ALU overwrite, then stale lc_done
        applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd11, LMAX, 1, 0, 5'd0);
        checkOutput("r11_long", 0, 1, 2'b00);
        applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd11, 3'(SB_LAT_ALU), 1, 0, 5'd0);
        checkOutput("r11_alu", 0, 1, 2'b00);
        applyStimulus(1, 2'b01, 5'd11, 5'd0, 0, 5'd0, 3'd0, 1, 1, 5'd11);
        checkOutput("r11_stale_done", 0, 1, 2'b00);
        applyStimulus(1, 2'b01, 5'd11, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("r11_after", 0, 1, 2'b00);

        // WAW with lat 3 overwrite; stale done must not clear the countdown
        applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd13, LMAX, 1, 0, 5'd0);
        checkOutput("r13_long", 0, 1, 2'b00);
        applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd13, 3'd3, 1, 0, 5'd0);
        checkOutput("r13_lat3", 0, 1, 2'b00);
        applyStimulus(1, 2'b01, 5'd13, 5'd0, 0, 5'd0, 3'd0, 1, 1, 5'd13);
        checkOutput("r13_stale_done", 1, 0, 2'b01);
        applyStimulus(1, 2'b01, 5'd13, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("r13_cnt2", 1, 0, 2'b01);
        applyStimulus(1, 2'b01, 5'd13, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("r13_cnt1", 1, 0, 2'b01);
        applyStimulus(1, 2'b01, 5'd13, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("r13_go", 0, 1, 2'b00);

        // $0 never tracked; disabled port ignored even if busy
        applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd14, LMAX, 1, 0, 5'd0);
        checkOutput("r14_long", 0, 1, 2'b00);
        applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd0, 3'(SB_LAT_LOAD), 1, 0, 5'd0);
        checkOutput("lw0_issue", 0, 1, 2'b00);
        applyStimulus(1, 2'b01, 5'd0, 5'd14, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("r0_read_rt_off", 0, 1, 2'b00);
        applyStimulus(1, 2'b11, 5'd0, 5'd14, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("r14_rt_on", 1, 0, 2'b10);
        applyStimulus(0, 2'b00, 5'd0, 5'd0, 0, 5'd0, 3'd0, 1, 1, 5'd14);
        checkOutput("r14_done_idle", 0, 0, 2'b00);
        applyStimulus(1, 2'b10, 5'd0, 5'd14, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("r14_released", 0, 1, 2'b00);

        // Source equals destination: checked against the older producer only
        applyStimulus(1, 2'b01, 5'd15, 5'd0, 1, 5'd15, 3'(SB_LAT_LOAD), 1, 0, 5'd0);
        checkOutput("r15_self", 0, 1, 2'b00);
        applyStimulus(1, 2'b01, 5'd15, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("r15_reader", 1, 0, 2'b01);
        applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd16, 3'(SB_LAT_LOAD), 1, 0, 5'd0);
        checkOutput("r16_issue", 0, 1, 2'b00);
        applyStimulus(1, 2'b01, 5'd16, 5'd0, 1, 5'd16, 3'(SB_LAT_ALU), 1, 0, 5'd0);
        checkOutput("r16_self_wait", 1, 0, 2'b01);
        applyStimulus(1, 2'b01, 5'd16, 5'd0, 1, 5'd16, 3'(SB_LAT_ALU), 1, 0, 5'd0);
        checkOutput("r16_self_go", 0, 1, 2'b00);
        applyStimulus(1, 2'b01, 5'd16, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("r16_alu_fwd", 0, 1, 2'b00);

`ifdef SCOREBOARD_PERF_EN
        applyStimulus(0, 2'b00, 5'd0, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        #1;
        nvec++;
        assert (perf_stall_cycles === 32'(exp_perf)) else begin
            nmis++;
            $error("[TB] FAIL perf_stall observed=%0d expected=%0d", perf_stall_cycles, exp_perf);
        end
`endif

        // Reset mid-countdown discards pending state
        applyStimulus(1, 2'b00, 5'd0, 5'd0, 1, 5'd20, LMAX, 1, 0, 5'd0);
        checkOutput("r20_long", 0, 1, 2'b00);
        doReset();
        applyStimulus(1, 2'b01, 5'd20, 5'd0, 0, 5'd0, 3'd0, 1, 0, 5'd0);
        checkOutput("r20_after_rst", 0, 1, 2'b00);
`ifdef SCOREBOARD_PERF_EN
        nvec++;
        assert (perf_stall_cycles === 32'd0) else begin
            nmis++;
            $error("[TB] FAIL perf_rst observed=%0d expected=0", perf_stall_cycles);
        end
`endif

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule

// File: doc/id_scoreboard.md
Name: id_scoreboard

Overview:
- Register-dependency scoreboard for the ID stage of the 5-stage MIPS pipeline.
- Generalises the single fixed load-use check into per-register ready countdowns. Covers N read ports, per-instruction result latency, and long-latency producers (mul/div, cache-miss loads) that finish asynchronously.
- Raises stall_req to ID when a source is not yet forwardable. The EX/MEM/WB forwarding mux stays in ID.

Parameters:
- NREG, 32, number of architectural GPRs; register 0 is never tracked.
- AW, 5, register address width, equal to log2(NREG).
- NRD, 2, number of source read ports (rs, rt).
- LAT_W, 3, latency field width; the value LAT_MAX = 2^LAT_W-1 means "wait for lc_done".

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- adv  in  1  EX and later stages advance this cycle (no downstream stall)
- id_valid  in  1  ID holds a valid instruction
- id_rs_en  in  NRD  per-port source-used flag
- id_raddr  in  NRD*AW  source addresses; port i = bits [i*AW +: AW]
- id_we  in  1  instruction writes a GPR
- id_waddr  in  AW  destination register
- id_lat  in  LAT_W  cycles after issue until the result is forwardable; 0 = ALU (EX forward), 1 = load, LAT_MAX = long-latency
- lc_done  in  1  long-latency unit result now forwardable
- lc_waddr  in  AW  destination of the completing long-latency op
- stall_req  out  1  ID must hold; combinational from state and ID inputs
- issue_fire  out  1  instruction leaves ID this cycle
- port_busy  out  NRD  per-port hazard flag (debug and forwarding qualification)

Behaviour:
- State: cnt[r], LAT_W bits, for r = 1..NREG-1. cnt = 0 means ready.
- Reset: all cnt cleared to 0 on rst at posedge clk, so stall_req = 0, issue_fire = 0, port_busy = 0 after reset. A reset mid-countdown discards all pending state.
- port_busy[i] = id_valid & id_rs_en[i] & (raddr_i != 0) & (cnt[raddr_i] != 0).
- stall_req = |port_busy.
- issue_fire = id_valid & adv & ~stall_req.
- Per register r, one update per cycle, applied in this priority:
  1. issue_fire & id_we & id_waddr == r & r != 0: cnt[r] <= id_lat. This covers WAW; the newest producer overwrites.
  2. lc_done & lc_waddr == r & cnt[r] == LAT_MAX: cnt[r] <= 0.
  3. adv & cnt[r] != 0 & cnt[r] != LAT_MAX: cnt[r] <= cnt[r] - 1.
  4. Otherwise hold.
- LAT_MAX is sticky. It never decrements and clears only on lc_done.
- lc_done for a register whose cnt != LAT_MAX (overwritten by a younger issue) is ignored.
- When adv = 0, counters freeze, because producers do not move.
- Hazard check uses pre-update state. An instruction whose source equals its own destination is checked against the older producer only.
- Issue with id_lat = 0 leaves cnt at 0, so the next instruction never stalls on it (EX forwarding).
- Latency: a dependent instruction stalls exactly id_lat advancing cycles after its producer issues. Example: load lat = 1 gives one bubble, matching the existing load-use behaviour.
- id_we with id_waddr = 0: no state change.

Optional Feature:
- Macro SCOREBOARD_PERF_EN.
- Defined: adds output perf_stall_cycles (32-bit). It increments when id_valid & stall_req, clears on rst, and wraps at 2^32-1 to 0. It also adds output perf_lc_pending (1-bit), the OR of all cnt == LAT_MAX.
- Undefined: neither port nor counter exists, and the core behaviour is identical.

Decomposition:
- Add to lib/defines.vh:
  - SB_LAT_ALU = 0
  - SB_LAT_LOAD = 1
  - SB_LAT_W default
  - the LAT_MAX derivation macro
  - the packed port-select helper width
- One sub-module, sb_entry: a single-register counter with issue/done/adv priority logic, generated NREG-1 times. The read-port compare and reduce stays in id_scoreboard.

Test Plan:
- Reset: rst for 2 cycles, then id_valid = 1, rs = 5, id_rs_en = 2'b01 → stall_req = 0, issue_fire = 1 (with adv = 1).
- Load-use: issue lw $8 with lat = 1, next instruction reads $8 with adv held 1 → stall_req = 1 for exactly 1 cycle, then issue_fire = 1. Repeat with the source at distance 2 → no stall.
- Frozen pipe: issue lat = 3 to $9, then adv = 0 for 4 cycles while a reader of $9 waits → stall_req stays 1. With adv back to 1, stall_req drops after 3 advancing cycles in total.
- Long-latency: issue div-type to $10 with lat = 7 (LAT_MAX), hold adv = 1 for 20 cycles → stall_req = 1 throughout. Pulse lc_done with lc_waddr = 10 → stall_req = 0 next cycle.
- WAW + stale done: issue $11 with lat = 7, then $11 with lat = 0, then lc_done with lc_waddr = 11 → a reader of $11 sees no stall after the second issue, and the lc_done causes no change.
- $0 and unused ports: issue lw $0 with lat = 1, then a reader of $0 with rt unused and id_rs_en = 2'b01 → stall_req = 0. With SCOREBOARD_PERF_EN defined, perf_stall_cycles counts exactly the stall cycles from the earlier scenarios.
